// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial LSB-first subtractor d = a - b with final borrow.
// Define SUBTRATOR_SERIAL_OVF_EN to add the signed overflow output ovf.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUBTRATOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb;
  logic br, ai, bi, diff, bnext, last;
  assign ai = sa[0];
  assign bi = sb[0];
  assign diff = ai ^ bi ^ br;
  assign bnext = (~ai & bi) | (~(ai ^ bi) & br);
  assign last = cnt == CW'(WIDTH - 1);
  // sa doubles as the result register: difference bits enter at the MSB as operand bits leave the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      br <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      d <= '0;
      bout <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa <= a;
            sb <= b;
            br <= 1'b0;
            cnt <= '0;
            busy <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa <= {diff, sa[WIDTH-1:1]};
          sb <= sb >> 1;
          br <= bnext;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            d <= {diff, sa[WIDTH-1:1]};
            bout <= bnext;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            ovf <= br ^ bnext;
`endif
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/subtrator_serial.md
SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend, captured on the accepted start edge.
REQ-007 busy  output  1  high while in SHIFT.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 d  output  WIDTH  difference a-b modulo 2^WIDTH.
REQ-010 bout  output  1  final borrow; 1 when unsigned a < b.
REQ-011 ovf  output  1  signed overflow flag (present only per REQ-029).

Function
REQ-012 States: IDLE, SHIFT, DONE; state register plus bit counter of ceil(log2(WIDTH+1)) bits.
REQ-013 IDLE with start=1 at an edge: load a and b into shift registers, clear the borrow flop, clear the counter, enter SHIFT.
REQ-014 IDLE with start=0: remain in IDLE; d and bout hold their last values.
REQ-015 SHIFT, each edge: take the LSB of each shift register, compute diff = a_i XOR b_i XOR bin and borrow = (~a_i & b_i) | (~(a_i XOR b_i) & bin), shift diff into the result MSB, shift the operands right, register the borrow, and increment the counter.
REQ-016 The datapath SHALL process exactly one bit per cycle, LSB first; no parallel WIDTH-bit subtractor.
REQ-017 On the edge that processes bit WIDTH-1: enter DONE, update d with the full result, and set bout to the final borrow.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-019 DONE: done=1 for exactly one cycle, then unconditionally return to IDLE; start is ignored while in DONE.
REQ-020 start is ignored in SHIFT, and a, b, d and bout are not disturbed by it.
REQ-021 d and bout SHALL hold from DONE until the next accepted start completes; they are not updated in intermediate SHIFT cycles.
REQ-022 Boundary behaviour: a==b gives d=0 and bout=0; a=0 with b=2^WIDTH-1 gives d=1 and bout=1.
REQ-023 busy=1 exactly in SHIFT; busy and done are never high together.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, clear the counter, and clear busy, done, d, bout and ovf to 0, regardless of clk.
REQ-025 Reset during SHIFT SHALL abort the operation with no done pulse; the first start after rst falls is accepted normally.
REQ-026 start asserted while rst=1 SHALL be ignored.

Configuration
REQ-027 Macro SUBTRATOR_SERIAL_OVF_EN.
REQ-028 Without the macro: the ovf port and its logic are absent.
REQ-029 With the macro: ovf is registered with d at DONE and equals the carry into the sign bit XOR bout (signed overflow of a-b); it holds with d.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x03, start at edge k -> done in the cycle after edge k+8, d=0x02, bout=0, ovf=0.
REQ-031 a=0x03, b=0x05 -> d=0xFE, bout=1, ovf=0.
REQ-032 a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1 (macro defined).
REQ-033 start pulsed again 3 cycles into SHIFT with different a/b -> ignored; first result delivered unchanged at the original done time.
REQ-034 rst asserted mid-SHIFT between clock edges -> busy=0 and d=0 without a clock edge, no done pulse; next start with a=0x00, b=0xFF -> d=0x01, bout=1.
REQ-035 Back-to-back: start held high continuously -> results every WIDTH+2 cycles, done pulses one cycle wide.
